mux_scan_ctrl: RTL

//   Sequencer that sits directly upstream of the 4:1 mux (G/C/X -> Y) and also consumes its output Y.
//   On request, it drives mux select C through channels 0..3 and holds each channel for DWELL cycles.
//   It samples Y once per channel and assembles the four samples into a 4-bit word.
//   The word is presented on a valid/ready handshake; between scans the mux is disabled (G=1).

---
 rtl/mux_scan_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an external 4:1 mux through channels 0..3, holding each
// channel for DWELL cycles, samples the mux output Y once per channel and
// presents the assembled 4-bit word on a valid/ready handshake.
//
// Handshake: DATA is offered while VALID=1 and is held stable until the cycle
// in which VALID && READY are both high at a rising edge; that edge consumes
// the word and VALID drops in the following cycle. VALID never drops without
// a transfer (RST excepted).
module mux_scan_ctrl #(
  parameter int DWELL = 2,  // cycles per channel, 1..255
  parameter bit CONT  = 1'b0  // restart automatically after each accepted word
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       G,
  output logic [1:0] C,
  input  logic       Y,
  output logic [3:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] shadow, shadow_n;
  logic [3:0] data_n;
  logic [1:0] c_n;
  logic       g_n, valid_n, busy_n;

  assign state_dbg = state;

  // State and all registered outputs; RST wins over every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      G      <= 1'b1;
      C      <= 2'd0;
      DATA   <= 4'd0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
      cnt    <= 8'd0;
      shadow <= 4'd0;
    end else begin
      state  <= state_n;
      G      <= g_n;
      C      <= c_n;
      DATA   <= data_n;
      VALID  <= valid_n;
      BUSY   <= busy_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_n  = state;
    g_n      = G;
    c_n      = C;
    data_n   = DATA;
    valid_n  = VALID;
    cnt_n    = cnt;
    shadow_n = shadow;

    case (state)
      IDLE: begin
        g_n = 1'b1;
        c_n = 2'd0;
        if (START) begin
          state_n = SETTLE;
          g_n     = 1'b0;
          c_n     = 2'd0;
          cnt_n   = RELOAD;
        end
      end

      SETTLE: begin
        g_n = 1'b0;
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          // Y reflects the registered C, so it belongs to channel C.
          shadow_n[C] = Y;
          if (C != 2'd3) begin
            c_n   = C + 2'd1;
            cnt_n = RELOAD;
          end else begin
            data_n  = shadow_n;
            valid_n = 1'b1;
            g_n     = 1'b1;
            c_n     = 2'd0;
            state_n = HOLD;
          end
        end
      end

      HOLD: begin
        g_n = 1'b1;
        if (VALID && READY) begin
          valid_n = 1'b0;
          if (CONT || START) begin
            state_n = SETTLE;
            g_n     = 1'b0;
            c_n     = 2'd0;
            cnt_n   = RELOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
        g_n     = 1'b1;
        c_n     = 2'd0;
        valid_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
